// File: rtl/dev_to_maxil_ot.sv
// Ibex LSU data port to AXI-Lite master bridge, up to MAX_OUTSTANDING in-flight, in-order completion.
// Optional macro DEV2MAXIL_ALIGN_CHECK_EN: misaligned or empty-strobe requests complete locally with error.

module dev_to_maxil_ot_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= nxt(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= nxt(rd_ptr_q);
         if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
         else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
endmodule

module dev_to_maxil_ot #(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        data_req_i,
   input  logic                        data_we_i,
   input  logic [31:0]                 data_addr_i,
   input  logic [3:0]                  data_be_i,
   input  logic [31:0]                 data_wdata_i,
   output logic                        data_gnt_o,
   output logic                        data_rvalid_o,
   output logic                        data_err_o,
   output logic [31:0]                 data_rdata_o,
   output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic                        M_AXI_AWVALID,
   input  logic                        M_AXI_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                        M_AXI_WVALID,
   input  logic                        M_AXI_WREADY,
   input  logic [1:0]                  M_AXI_BRESP,
   input  logic                        M_AXI_BVALID,
   output logic                        M_AXI_BREADY,
   output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY
);
   localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW   = AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {OP_WR = 2'd0, OP_RD = 2'd1, OP_LERR = 2'd2} op_e;

   generate
      if (AXI_DATA_WIDTH != 32) begin : g_bad_dw
         $error("dev_to_maxil_ot: AXI_DATA_WIDTH must be 32");
      end
      if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
          (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_mo
         $error("dev_to_maxil_ot: MAX_OUTSTANDING must be a power of two in 1..16");
      end
   endgenerate

   logic                      aw_pend_q, w_pend_q, ar_pend_q, ready_q;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q, addr_ext;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [SW-1:0]             wstrb_q;
   logic [CNTW-1:0]           cnt_q, cnt_d;
   logic                      rvalid_q, rvalid_d, err_q, err_d;
   logic [31:0]               rdata_q, rdata_d;

   logic                      bad_req, gnt_wr, gnt_rd;
   logic [1:0]                ord_din, ord_dout;
   logic                      ord_empty, b_empty, r_empty;
   logic                      b_dout;
   logic [AXI_DATA_WIDTH:0]   r_in, r_dout, r_head;
   logic                      b_hs, r_hs, b_head_err, b_avail, r_avail;
   logic                      head_wr, head_rd, head_lerr;
   logic                      cmpl, cmpl_wr, cmpl_rd;

   assign addr_ext = AXI_ADDR_WIDTH'(data_addr_i);

`ifdef DEV2MAXIL_ALIGN_CHECK_EN
   assign bad_req = (data_addr_i[1:0] != 2'b00) || (data_be_i == 4'b0000);
`else
   assign bad_req = 1'b0;
`endif

   assign data_gnt_o = data_req_i && (cnt_q < CNTW'(MAX_OUTSTANDING)) &&
                       (data_we_i ? (!aw_pend_q && !w_pend_q) : !ar_pend_q);
   assign gnt_wr  = data_gnt_o && data_we_i && !bad_req;
   assign gnt_rd  = data_gnt_o && !data_we_i && !bad_req;
   assign ord_din = bad_req ? OP_LERR : (data_we_i ? OP_WR : OP_RD);

   // A response arriving this cycle can retire the head directly, bypassing
   // its FIFO, so the handshake-to-rvalid latency is a single cycle.
   assign b_hs       = M_AXI_BVALID && ready_q;
   assign r_hs       = M_AXI_RVALID && ready_q;
   assign r_in       = {(M_AXI_RRESP != 2'b00), M_AXI_RDATA};
   assign b_avail    = !b_empty || b_hs;
   assign r_avail    = !r_empty || r_hs;
   assign b_head_err = b_empty ? (M_AXI_BRESP != 2'b00) : b_dout;
   assign r_head     = r_empty ? r_in : r_dout;

   assign head_wr   = (ord_dout == OP_WR);
   assign head_rd   = (ord_dout == OP_RD);
   assign head_lerr = (ord_dout == OP_LERR);
   assign cmpl      = !ord_empty && ((head_wr && b_avail) || (head_rd && r_avail) || head_lerr);
   assign cmpl_wr   = cmpl && head_wr;
   assign cmpl_rd   = cmpl && head_rd;

   dev_to_maxil_ot_fifo #(.WIDTH(2), .DEPTH(MAX_OUTSTANDING)) u_ord (
      .clk(clk), .rst_n(rst_n), .push_i(data_gnt_o), .din_i(ord_din),
      .pop_i(cmpl), .dout_o(ord_dout), .empty_o(ord_empty)
   );

   dev_to_maxil_ot_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_bfifo (
      .clk(clk), .rst_n(rst_n), .push_i(b_hs && !(cmpl_wr && b_empty)),
      .din_i(M_AXI_BRESP != 2'b00), .pop_i(cmpl_wr && !b_empty),
      .dout_o(b_dout), .empty_o(b_empty)
   );

   dev_to_maxil_ot_fifo #(.WIDTH(AXI_DATA_WIDTH + 1), .DEPTH(MAX_OUTSTANDING)) u_rfifo (
      .clk(clk), .rst_n(rst_n), .push_i(r_hs && !(cmpl_rd && r_empty)),
      .din_i(r_in), .pop_i(cmpl_rd && !r_empty),
      .dout_o(r_dout), .empty_o(r_empty)
   );

   always_comb begin
      cnt_d    = cnt_q;
      rvalid_d = cmpl;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      if (data_gnt_o && !cmpl)      cnt_d = cnt_q + CNTW'(1);
      else if (cmpl && !data_gnt_o) cnt_d = cnt_q - CNTW'(1);
      if (cmpl) begin
         err_d   = head_lerr || (head_wr && b_head_err) || (head_rd && r_head[AXI_DATA_WIDTH]);
         rdata_d = head_rd ? r_head[AXI_DATA_WIDTH-1:0] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         ar_pend_q <= 1'b0;
         ready_q   <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q  <= 1'b1;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         if (gnt_wr) begin
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            awaddr_q  <= addr_ext;
            wdata_q   <= AXI_DATA_WIDTH'(data_wdata_i);
            wstrb_q   <= SW'(data_be_i);
         end else begin
            if (aw_pend_q && M_AXI_AWREADY) aw_pend_q <= 1'b0;
            if (w_pend_q && M_AXI_WREADY)   w_pend_q  <= 1'b0;
         end
         if (gnt_rd) begin
            ar_pend_q <= 1'b1;
            araddr_q  <= addr_ext;
         end else if (ar_pend_q && M_AXI_ARREADY) begin
            ar_pend_q <= 1'b0;
         end
      end
   end

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = aw_pend_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = w_pend_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = ar_pend_q;
   assign M_AXI_BREADY  = ready_q;
   assign M_AXI_RREADY  = ready_q;
   assign data_rvalid_o = rvalid_q;
   assign data_err_o    = err_q;
   assign data_rdata_o  = rdata_q;
endmodule

// File: tb/tb_dev_to_maxil_ot.sv
// Scoreboard bench for dev_to_maxil_ot with a configurable AXI-Lite slave model.
module tb_dev_to_maxil_ot;
   logic        clk, rst_n;
   logic        data_req_i, data_we_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic [3:0]  data_be_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

   dev_to_maxil_ot dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int tests, fails;
   logic [32:0] exp_q [$];
   int rv_cnt, last_rv_cyc;

   // slave configuration and observations
   int          aw_delay, w_delay, ar_delay;
   bit          stall_b, stall_r;
   logic [1:0]  bresp_cfg;
   int          aw_beats, w_beats, ar_beats, r_beats, b_beats;
   logic [31:0] last_awaddr, last_wdata, last_araddr;
   logic [3:0]  last_wstrb;

   // slave internal state
   logic        awv_s, awr_d, wv_s, wr_d, arv_s, arr_d, bv_d, br_s, rv_d, rr_s;
   logic [31:0] awa_s, wd_s, ara_s;
   logic [3:0]  ws_s;
   int          awage, wage, arage, aw_done, w_done, b_iss;
   logic [1:0]  bq [$];
   logic [33:0] rq [$];
   logic [1:0]  bdummy;
   logic [33:0] rdummy;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a == 32'h1000) ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
   endfunction

   initial begin : slave
      {awv_s, awr_d, wv_s, wr_d, arv_s, arr_d, bv_d, br_s, rv_d, rr_s} = '0;
      {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID} = '0;
      M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) begin
            {awv_s, awr_d, wv_s, wr_d, arv_s, arr_d, bv_d, br_s, rv_d, rr_s} = '0;
            awage = 0; wage = 0; arage = 0; aw_done = 0; w_done = 0; b_iss = 0;
            bq.delete(); rq.delete();
         end else begin
            if (awv_s && awr_d) begin aw_beats++; aw_done++; last_awaddr = awa_s; awage = 0; end
            if (wv_s && wr_d) begin w_beats++; w_done++; last_wdata = wd_s; last_wstrb = ws_s; wage = 0; end
            if (arv_s && arr_d) begin
               ar_beats++; last_araddr = ara_s; arage = 0;
               rq.push_back({2'b00, mem_rd(ara_s)});
            end
            if (bv_d && br_s) begin b_beats++; bdummy = bq.pop_front(); end
            if (rv_d && rr_s) begin r_beats++; rdummy = rq.pop_front(); end
            while (aw_done > b_iss && w_done > b_iss) begin bq.push_back(bresp_cfg); b_iss++; end
            awv_s = M_AXI_AWVALID; awa_s = M_AXI_AWADDR;
            wv_s = M_AXI_WVALID; wd_s = M_AXI_WDATA; ws_s = M_AXI_WSTRB;
            arv_s = M_AXI_ARVALID; ara_s = M_AXI_ARADDR;
            br_s = M_AXI_BREADY; rr_s = M_AXI_RREADY;
            awr_d = awv_s && (awage >= aw_delay); awage = awv_s ? awage + 1 : 0;
            wr_d  = wv_s && (wage >= w_delay);    wage  = wv_s ? wage + 1 : 0;
            arr_d = arv_s && (arage >= ar_delay); arage = arv_s ? arage + 1 : 0;
            bv_d = (bq.size() != 0) && !stall_b;
            rv_d = (rq.size() != 0) && !stall_r;
         end
         M_AXI_AWREADY = awr_d; M_AXI_WREADY = wr_d; M_AXI_ARREADY = arr_d;
         M_AXI_BVALID = bv_d; M_AXI_BRESP = bv_d ? bq[0] : 2'b00;
         M_AXI_RVALID = rv_d;
         M_AXI_RDATA = rv_d ? rq[0][31:0] : 32'h0;
         M_AXI_RRESP = rv_d ? rq[0][33:32] : 2'b00;
      end
   end

   initial begin : monitor
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && data_rvalid_o) begin
            rv_cnt++; last_rv_cyc = cyc; tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected got err=%0d rdata=%h, required no completion", data_err_o, data_rdata_o);
            end else begin
               e = exp_q.pop_front();
               if ({data_err_o, data_rdata_o} !== e) begin
                  fails++;
                  $display("FAIL sb_compare got err=%0d rdata=%h, required err=%0d rdata=%h",
                           data_err_o, data_rdata_o, e[32], e[31:0]);
               end
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [32:0] exp, output int gcyc);
      int n = 0;
      @(negedge clk);
      data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
      #2;
      while (!data_gnt_o && n < 50) begin @(negedge clk); #2; n++; end
      tests++;
      if (!data_gnt_o) begin
         fails++; gcyc = -1;
         $display("FAIL gnt_timeout addr=%h got gnt=0, required gnt=1", addr);
      end else begin
         exp_q.push_back(exp); gcyc = cyc;
      end
      @(posedge clk); #1;
      data_req_i = 1'b0;
   endtask

   task automatic wait_rv(input int target, input int budget);
      int n = 0;
      while (rv_cnt < target && n < budget) begin @(negedge clk); #2; n++; end
      tests++;
      if (rv_cnt < target) begin
         fails++;
         $display("FAIL rvalid_timeout got %0d completions, required %0d", rv_cnt, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_be_i = 0; data_wdata_i = 0;
      #1 rst_n = 1'b0;
      #2;
      tests++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID} !== 3'b000) begin fails++;
         $display("FAIL reset_valids got %b, required 000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}); end
      tests++; if ({M_AXI_BREADY, M_AXI_RREADY} !== 2'b00) begin fails++;
         $display("FAIL reset_readies got %b, required 00", {M_AXI_BREADY, M_AXI_RREADY}); end
      tests++; if ({data_rvalid_o, data_err_o} !== 2'b00 || data_rdata_o !== 32'h0) begin fails++;
         $display("FAIL reset_core got rvalid=%0d err=%0d rdata=%h, required 0/0/0", data_rvalid_o, data_err_o, data_rdata_o); end
      tests++; if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR} !== 100'h0) begin fails++;
         $display("FAIL reset_payload got aw=%h w=%h s=%h ar=%h, required 0", M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #2;
      tests++; if ({M_AXI_BREADY, M_AXI_RREADY} !== 2'b11) begin fails++;
         $display("FAIL ready_after_reset got %b, required 11", {M_AXI_BREADY, M_AXI_RREADY}); end
   endtask

   task automatic test_read_latency();
      int g; int r0 = rv_cnt;
      issue(1'b0, 32'h1000, 4'hF, 32'h0, {1'b0, 32'hDEADBEEF}, g);
      wait_rv(r0 + 1, 20);
      tests++; if (last_rv_cyc - g != 3) begin fails++;
         $display("FAIL read_latency got %0d cycles, required 3", last_rv_cyc - g); end
   endtask

   task automatic test_write_w_first();
      int g; int r0 = rv_cnt; int a0 = aw_beats; int w0 = w_beats;
      aw_delay = 5; w_delay = 0;
      issue(1'b1, 32'h2004, 4'b0011, 32'h12345678, {1'b0, 32'h0}, g);
      wait_rv(r0 + 1, 40);
      repeat (3) @(negedge clk); #2;
      aw_delay = 0;
      tests++; if (aw_beats - a0 != 1 || w_beats - w0 != 1) begin fails++;
         $display("FAIL write_beats got aw=%0d w=%0d, required 1/1", aw_beats - a0, w_beats - w0); end
      tests++; if (last_wstrb !== 4'b0011) begin fails++;
         $display("FAIL write_wstrb got %b, required 0011", last_wstrb); end
      tests++; if (last_awaddr !== 32'h2004 || last_wdata !== 32'h12345678) begin fails++;
         $display("FAIL write_payload got %h/%h, required 00002004/12345678", last_awaddr, last_wdata); end
      tests++; if (rv_cnt - r0 != 1) begin fails++;
         $display("FAIL write_single_rvalid got %0d, required 1", rv_cnt - r0); end
   endtask

   task automatic test_back_to_back();
      int g1, g2, g3, g4; int r0 = rv_cnt;
      issue(1'b0, 32'h1200, 4'hF, 32'h0, {1'b0, mem_rd(32'h1200)}, g1);
      issue(1'b0, 32'h1204, 4'hF, 32'h0, {1'b0, mem_rd(32'h1204)}, g2);
      tests++; if (g2 - g1 != 2) begin fails++;
         $display("FAIL rd_after_rd got gap %0d, required 2", g2 - g1); end
      issue(1'b1, 32'h2200, 4'hF, 32'hCAFEF00D, {1'b0, 32'h0}, g3);
      issue(1'b0, 32'h1208, 4'hF, 32'h0, {1'b0, mem_rd(32'h1208)}, g4);
      tests++; if (g4 - g3 != 1) begin fails++;
         $display("FAIL rd_after_wr got gap %0d, required 1", g4 - g3); end
      wait_rv(r0 + 4, 40);
   endtask

   task automatic test_outstanding();
      int g, blocked, n; int r0;
      stall_r = 1'b1;
      r0 = rv_cnt;
      for (int i = 0; i < 4; i++)
         issue(1'b0, 32'h1300 + 32'(4 * i), 4'hF, 32'h0, {1'b0, mem_rd(32'h1300 + 32'(4 * i))}, g);
      @(negedge clk);
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h1400; data_be_i = 4'hF;
      #2; blocked = 0;
      for (int i = 0; i < 6; i++) begin if (data_gnt_o) blocked++; @(negedge clk); #2; end
      tests++; if (blocked != 0) begin fails++;
         $display("FAIL cap_gnt got %0d grants while full, required 0", blocked); end
      stall_r = 1'b0; n = 0;
      while (!data_gnt_o && n < 30) begin @(negedge clk); #2; n++; end
      tests++; if (!data_gnt_o || rv_cnt != r0 + 1 || last_rv_cyc != cyc) begin fails++;
         $display("FAIL cap_release got gnt=%0d completions=%0d, required gnt=1 completions=1 in same cycle",
                  data_gnt_o, rv_cnt - r0); end
      if (data_gnt_o) exp_q.push_back({1'b0, mem_rd(32'h1400)});
      @(posedge clk); #1; data_req_i = 1'b0;
      issue(1'b0, 32'h1404, 4'hF, 32'h0, {1'b0, mem_rd(32'h1404)}, g);
      wait_rv(r0 + 6, 40);
   endtask

   task automatic test_order_r_before_b();
      int g, n; int r0 = rv_cnt; int rb0 = r_beats;
      stall_b = 1'b1; bresp_cfg = 2'b10;
      issue(1'b1, 32'h2100, 4'hF, 32'h11112222, {1'b1, 32'h0}, g);
      issue(1'b0, 32'h1100, 4'hF, 32'h0, {1'b0, mem_rd(32'h1100)}, g);
      n = 0;
      while (r_beats == rb0 && n < 20) begin @(negedge clk); #2; n++; end
      repeat (2) @(negedge clk); #2;
      tests++; if (r_beats == rb0 || rv_cnt != r0) begin fails++;
         $display("FAIL order_hold got r_beats=%0d completions=%0d, required r accepted and 0 completions",
                  r_beats - rb0, rv_cnt - r0); end
      stall_b = 1'b0;
      wait_rv(r0 + 2, 20);
      bresp_cfg = 2'b00;
   endtask

   task automatic test_misaligned();
      int g; int r0 = rv_cnt; int a0 = ar_beats;
`ifdef DEV2MAXIL_ALIGN_CHECK_EN
      int seen = 0;
      stall_b = 1'b1;
      issue(1'b1, 32'h2000, 4'hF, 32'h0BADF00D, {1'b0, 32'h0}, g);
      issue(1'b0, 32'h3002, 4'hF, 32'h0, {1'b1, 32'h0}, g);
      for (int i = 0; i < 6; i++) begin @(negedge clk); #2; if (M_AXI_ARVALID) seen++; end
      tests++; if (seen != 0 || ar_beats != a0) begin fails++;
         $display("FAIL lerr_no_ar got arvalid cycles=%0d beats=%0d, required 0/0", seen, ar_beats - a0); end
      tests++; if (rv_cnt != r0) begin fails++;
         $display("FAIL lerr_in_order got %0d completions before write, required 0", rv_cnt - r0); end
      stall_b = 1'b0;
      wait_rv(r0 + 2, 20);
`else
      issue(1'b0, 32'h3002, 4'hF, 32'h0, {1'b0, mem_rd(32'h3002)}, g);
      wait_rv(r0 + 1, 20);
      tests++; if (ar_beats - a0 != 1 || last_araddr !== 32'h3002) begin fails++;
         $display("FAIL passthrough_addr got beats=%0d araddr=%h, required 1/00003002", ar_beats - a0, last_araddr); end
`endif
   endtask

   task automatic test_reset_midop();
      int g; int r0;
      stall_b = 1'b1; stall_r = 1'b1;
      issue(1'b0, 32'h1500, 4'hF, 32'h0, {1'b0, mem_rd(32'h1500)}, g);
      issue(1'b0, 32'h1504, 4'hF, 32'h0, {1'b0, mem_rd(32'h1504)}, g);
      issue(1'b1, 32'h2500, 4'hF, 32'h55AA55AA, {1'b0, 32'h0}, g);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
                    data_rvalid_o, data_err_o} !== 7'b0 || data_rdata_o !== 32'h0) begin fails++;
         $display("FAIL midop_reset_outputs got %b rdata=%h, required all 0",
                  {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
                   data_rvalid_o, data_err_o}, data_rdata_o); end
      exp_q.delete();
      repeat (2) @(negedge clk);
      stall_b = 1'b0; stall_r = 1'b0;
      rst_n = 1'b1;
      #2;
      tests++; if (dut.cnt_q !== '0) begin fails++;
         $display("FAIL midop_cnt got %0d, required 0", dut.cnt_q); end
      r0 = rv_cnt;
      issue(1'b0, 32'h1000, 4'hF, 32'h0, {1'b0, 32'hDEADBEEF}, g);
      wait_rv(r0 + 1, 20);
   endtask

   initial begin
      tests = 0; fails = 0; rv_cnt = 0; last_rv_cyc = 0;
      aw_delay = 0; w_delay = 0; ar_delay = 0; stall_b = 0; stall_r = 0; bresp_cfg = 2'b00;
      aw_beats = 0; w_beats = 0; ar_beats = 0; r_beats = 0; b_beats = 0;
      last_awaddr = 0; last_wdata = 0; last_araddr = 0; last_wstrb = 0;
      test_reset();
      test_read_latency();
      test_write_w_first();
      test_back_to_back();
      test_outstanding();
      test_order_r_before_b();
      test_misaligned();
      test_reset_midop();
      repeat (3) @(negedge clk);
      tests++; if (exp_q.size() != 0) begin fails++;
         $display("FAIL sb_leftover got %0d pending, required 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
endmodule
